fetch_stage: RTL and testbench

Instruction-fetch (IF) stage of the pipelined LEGv8 core. Holds the program counter, drives the word address of the combinational instruction ROM, and captures the returned instruction together with its PC into the IF/ID pipeline register. Sits directly upstream of the instruction ROM and feeds the decode stage. Honours stall, flush, branch redirect and halt requests from the hazard and branch logic.

---
 rtl/fetch_stage_if.sv | 45 ++++
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage and its environment (instruction ROM, hazard/branch logic, decode).
// The master modport is the fetch stage; the slave modport is everything around it.
interface fetch_stage_if #(
  parameter int N = 64
) ();
  logic [5:0]   imem_addr;
  logic [31:0]  imem_q;
  logic         pcsrc;
  logic [N-1:0] branch_target;
  logic         stall;
  logic         flush;
  logic         halt_req;
  logic [N-1:0] if_id_pc;
  logic [31:0]  if_id_instr;
  logic         if_id_valid;
  logic         halted;

  modport master (
    output imem_addr,
    input  imem_q,
    input  pcsrc,
    input  branch_target,
    input  stall,
    input  flush,
    input  halt_req,
    output if_id_pc,
    output if_id_instr,
    output if_id_valid,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_q,
    output pcsrc,
    output branch_target,
    output stall,
    output flush,
    output halt_req,
    input  if_id_pc,
    input  if_id_instr,
    input  if_id_valid,
    input  halted
  );
endinterface

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, ROM addressing and IF/ID capture with RUN/HALT control.
// Optional BRANCH_AUTOFLUSH_EN: a taken branch also bubbles IF/ID on the same edge.
module fetch_stage (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);
  localparam int N = $bits(bus.if_id_pc);

  typedef enum logic {RUN, HALT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pc_p0, pc_p0_d;
  logic [N-1:0]   pc_p1, pc_p1_d;
  logic [31:0]    instr_p1, instr_p1_d;
  logic           vld_p1, vld_p1_d;
  logic [N-1:0]   target;
  logic           autoflush;
  logic           bubble;
  logic           hold_id;
  logic           unused_tgt_lsb;

`ifdef BRANCH_AUTOFLUSH_EN
  assign autoflush = bus.pcsrc;
`else
  assign autoflush = 1'b0;
`endif

  // Low two bits of the redirect address are dropped: fetch is always word aligned.
  assign target         = {bus.branch_target[N-1:2], 2'b00};
  assign unused_tgt_lsb = ^bus.branch_target[1:0];

  // Stage p0: PC register and ROM address
  assign bus.imem_addr = pc_p0[7:2];

  always_comb begin
    state_d    = state_q;
    pc_p0_d    = pc_p0;
    bubble     = 1'b0;
    hold_id    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.pcsrc)         pc_p0_d = target;
        else if (bus.halt_req) state_d = HALT;
        else if (!bus.stall)   pc_p0_d = pc_p0 + N'(4);

        if ((bus.halt_req && !bus.pcsrc) || bus.flush || autoflush) bubble  = 1'b1;
        else if (bus.stall)                                          hold_id = 1'b1;
      end
      HALT: begin
        bubble = 1'b1;
        if (bus.pcsrc) begin
          pc_p0_d = target;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Stage p1: IF/ID pipeline register
  always_comb begin
    pc_p1_d    = pc_p0;
    instr_p1_d = bus.imem_q;
    vld_p1_d   = 1'b1;
    if (bubble) begin
      pc_p1_d    = '0;
      instr_p1_d = 32'h0000_0000;
      vld_p1_d   = 1'b0;
    end else if (hold_id) begin
      pc_p1_d    = pc_p1;
      instr_p1_d = instr_p1;
      vld_p1_d   = vld_p1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      pc_p0    <= '0;
      pc_p1    <= '0;
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_p0    <= pc_p0_d;
      pc_p1    <= pc_p1_d;
      instr_p1 <= instr_p1_d;
      vld_p1   <= vld_p1_d;
    end
  end

  assign bus.if_id_pc    = pc_p1;
  assign bus.if_id_instr = instr_p1;
  assign bus.if_id_valid = vld_p1;
  assign bus.halted      = (state_q == HALT);
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fetch order, stall, redirect, flush, wrap, halt and async reset.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] rom [64];

  fetch_stage_if #(.N(64)) bus ();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_q = rom[bus.imem_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                          input logic vld);
    chk({tag, ".pc"}, bus.if_id_pc, pc);
    chk({tag, ".instr"}, 64'(bus.if_id_instr), 64'(instr));
    chk({tag, ".valid"}, 64'(bus.if_id_valid), 64'(vld));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hf800_0000 + (i << 15) + i;
    reset = 1'b1;
    bus.pcsrc = 1'b0;
    bus.branch_target = '0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.halt_req = 1'b0;

    #12;
    chk("rst.addr", 64'(bus.imem_addr), 64'd0);
    chk_ifid("rst", 64'd0, 32'h0, 1'b0);
    chk("rst.halted", 64'(bus.halted), 64'd0);
    reset = 1'b0;

    // Sequential fetch of ROM[0..2]
    step(); chk_ifid("e1", 64'h0, 32'hf800_0000, 1'b1); chk("e1.addr", 64'(bus.imem_addr), 64'd1);
    step(); chk_ifid("e2", 64'h4, 32'hf800_8001, 1'b1);
    bus.stall = 1'b1;
    step(); chk_ifid("st1", 64'h4, 32'hf800_8001, 1'b1); chk("st1.addr", 64'(bus.imem_addr), 64'd2);
    step(); chk_ifid("st2", 64'h4, 32'hf800_8001, 1'b1); chk("st2.addr", 64'(bus.imem_addr), 64'd2);
    bus.stall = 1'b0;
    step(); chk_ifid("e5", 64'h8, 32'hf801_0002, 1'b1);
    step(); chk_ifid("e6", 64'hC, 32'hf801_8003, 1'b1); chk("e6.addr", 64'(bus.imem_addr), 64'd4);

    // Redirect to 0x47 from PC=0x10
    bus.pcsrc = 1'b1; bus.branch_target = 64'h47;
    step();
    chk("br.addr", 64'(bus.imem_addr), 64'd17);
`ifdef BRANCH_AUTOFLUSH_EN
    chk_ifid("br", 64'h0, 32'h0, 1'b0);
`else
    chk_ifid("br", 64'h10, 32'hf802_0004, 1'b1);
`endif
    bus.pcsrc = 1'b0;
    step(); chk_ifid("br+1", 64'h44, 32'hf808_8011, 1'b1);

    // Flush
    bus.flush = 1'b1;
    step(); chk_ifid("fl", 64'h0, 32'h0, 1'b0); chk("fl.addr", 64'(bus.imem_addr), 64'd19);
    bus.flush = 1'b0;
    step(); chk_ifid("fl+1", 64'h4C, 32'hf809_8013, 1'b1);

    // pcsrc together with stall
    bus.pcsrc = 1'b1; bus.stall = 1'b1; bus.branch_target = 64'h20;
    step();
    chk("bs.addr", 64'(bus.imem_addr), 64'd8);
`ifdef BRANCH_AUTOFLUSH_EN
    chk_ifid("bs", 64'h0, 32'h0, 1'b0);
`else
    chk_ifid("bs", 64'h4C, 32'hf809_8013, 1'b1);
`endif
    bus.pcsrc = 1'b0; bus.stall = 1'b0;
    step(); chk_ifid("bs+1", 64'h20, 32'hf804_0008, 1'b1);

    // 256-byte wrap of imem_addr
    bus.pcsrc = 1'b1; bus.branch_target = 64'hF8;
    step(); bus.pcsrc = 1'b0;
    step(); chk_ifid("w1", 64'hF8, 32'hf81f_003e, 1'b1); chk("w1.addr", 64'(bus.imem_addr), 64'd63);
    step(); chk_ifid("w2", 64'hFC, 32'hf81f_803f, 1'b1); chk("w2.addr", 64'(bus.imem_addr), 64'd0);
    step(); chk_ifid("w3", 64'h100, 32'hf800_0000, 1'b1);

    // Full 64-bit PC wrap
    bus.pcsrc = 1'b1; bus.branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); bus.pcsrc = 1'b0; chk("wf.addr", 64'(bus.imem_addr), 64'd63);
    step(); chk_ifid("wf", 64'hFFFF_FFFF_FFFF_FFFC, 32'hf81f_803f, 1'b1);
    chk("wf.addr0", 64'(bus.imem_addr), 64'd0);
    step(); chk_ifid("wf+1", 64'h0, 32'hf800_0000, 1'b1);

    // Halt, stall toggling, then resume via branch
    bus.halt_req = 1'b1;
    step(); bus.halt_req = 1'b0;
    chk("h.halted", 64'(bus.halted), 64'd1); chk_ifid("h", 64'h0, 32'h0, 1'b0);
    chk("h.addr", 64'(bus.imem_addr), 64'd1);
    bus.stall = 1'b1;
    step(); chk("h2.addr", 64'(bus.imem_addr), 64'd1); chk("h2.valid", 64'(bus.if_id_valid), 64'd0);
    bus.stall = 1'b0;
    step(); chk("h3.addr", 64'(bus.imem_addr), 64'd1); chk("h3.halted", 64'(bus.halted), 64'd1);
    bus.pcsrc = 1'b1; bus.branch_target = 64'h0; bus.halt_req = 1'b1;
    step(); bus.pcsrc = 1'b0; bus.halt_req = 1'b0;
    chk("hr.halted", 64'(bus.halted), 64'd0); chk("hr.addr", 64'(bus.imem_addr), 64'd0);
    chk_ifid("hr", 64'h0, 32'h0, 1'b0);
    step(); chk_ifid("hr+1", 64'h0, 32'hf800_0000, 1'b1);

    // Asynchronous reset mid-cycle
    step(); chk_ifid("pre", 64'h4, 32'hf800_8001, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_ifid("ar", 64'h0, 32'h0, 1'b0);
    chk("ar.addr", 64'(bus.imem_addr), 64'd0);
    chk("ar.halted", 64'(bus.halted), 64'd0);
    @(negedge clk) reset = 1'b0;
    step(); chk_ifid("ar+1", 64'h0, 32'hf800_0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
